jk_excitation_sequencer: RTL and testbench
==========================================

# jk_excitation_sequencer

Drives the J/K inputs of a positive-edge JK flip-flop so that its output Q follows a loaded target bit pattern, one bit per clock. It is the stimulus side of the JK excitation table. It observes the flip-flop's Q as feedback and counts every cycle where Q did not reach the commanded value. It sits beside an `FFJK_posedge` instance, on the same clock, as a self-checking pattern generator.

## Interface
- `WIDTH`, default 16: maximum pattern length in bits.
- `DC_POLICY`, default 0: value driven on the excitation "don't-care" input. 0 uses hold/set/reset only and never toggles. 1 prefers toggle.
- `LEN_W`, default `$clog2(WIDTH+1)`: width of `length`.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of `err_count`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `pattern`  in  WIDTH  target Q sequence; `pattern[0]` is applied first. Latched on accepted `start`.
- `length`  in  LEN_W  number of bits to apply. Latched on accepted `start`. Valid range 0..WIDTH; values above WIDTH are clamped to WIDTH.
- `q_fb`  in  1  Q output of the driven flip-flop.
- `j`, `k`  out  1 each  flip-flop excitation.
- `busy`  out  1  high in RUN and FLUSH.
- `done`  out  1  one-cycle pulse at the end of a sequence.
- `err_count`  out  CNT_W  number of mismatches in the last or current sequence.
- `err_flag`  out  1  high when `err_count` is nonzero.

## Operation
- States: IDLE, RUN, FLUSH.
- **IDLE, `start` = 1:**
  - Latch `pattern` and the clamped `length`.
  - Set `idx` = 0 and clear `err_count`.
  - Go to RUN; if `length` is 0, go to FLUSH instead.
- **RUN, bit `idx`, target `t` = `pattern[idx]`.** `j`/`k` are combinational from `q_fb` and `t`:
  - Q 0 → t 0: j = 0, k = DC_POLICY.
  - Q 0 → t 1: j = 1, k = DC_POLICY.
  - Q 1 → t 0: j = DC_POLICY, k = 1.
  - Q 1 → t 1: j = DC_POLICY, k = 0.
- **RUN, each edge:**
  - Register `exp` = `t` and set `chk_vld` = 1.
  - If `chk_vld` was already 1, compare `q_fb` with the previous `exp`.
  - Increment `idx`.
  - When `idx` = `length`−1 at the edge, go to FLUSH.
- **FLUSH:**
  - Drive j = k = 0 (hold).
  - Perform the final pending compare, if `chk_vld` = 1.
  - Pulse `done` and return to IDLE.
- **IDLE:** j = k = 0; `err_count` holds its last value.
- **Mismatch:** `q_fb` ≠ `exp`, or `q_fb` is non-0/1 in simulation. Each mismatch increments `err_count`, which saturates at 2^CNT_W−1.
- `start` while `busy` is ignored and does not queue.
- **`reset` asserted in any state:**
  - Next edge enters IDLE with j = k = 0, `busy` = 0, `done` = 0, `err_count` = 0, `err_flag` = 0.
  - Internal state cleared: `idx` = 0, `chk_vld` = 0, `exp` = 0.
  - A sequence in progress is abandoned with no `done` pulse.
- Reset has priority over `start` in the same cycle.

## Timing
- Accept latency: `start` sampled at edge E0 → RUN from E0. Bit 0 is applied to the flip-flop at edge E1.
- Bit i lands in Q at edge E(i+1) and is checked at edge E(i+2).
- A sequence of length L ≥ 1:
  - `busy` is high for L+1 cycles (L RUN cycles, 1 FLUSH cycle).
  - `done` is high during the FLUSH cycle, i.e. the cycle after edge E(L).
  - `err_count` is final and valid from edge E(L+1), when `done` deasserts.
- L = 0: one FLUSH cycle, `done` pulses, `err_count` = 0.
- A new `start` can be accepted the first cycle `done` is low, i.e. back-to-back sequences with one idle gap.
- `j`/`k` settle combinationally from `q_fb` within the cycle. There is no register on `j`/`k`, so the flip-flop sees the excitation of the current bit.

## Structure
- Shared package `jk_seq_pkg` contains:
  - The state enum (IDLE, RUN, FLUSH).
  - The `DC_POLICY` encoding constants.
  - The function `jk_excite(q, t, dc)` that returns {j, k}. Shared with the bench's reference model.
- One natural sub-module, `jk_excite_cell`: combinational excitation-table lookup. The FSM, index counter and error counter stay in the top module.

## Test plan
- **Alternating pattern, policy 0.** `reset` held 2 cycles, then released; `DC_POLICY` = 0, `pattern` = 16'hA5A5, `length` = 16, `start` pulsed, driving `FFJK_posedge` (its `reset_async` held high) → Q follows 1,0,1,0,0,1,0,1,…; `done` at cycle 17 after `start`; `err_count` = 0; `k` never 1 while Q = 0.
- **Toggle policy.** Same stimulus with `DC_POLICY` = 1 → every bit change is driven with j = k = 1; `err_count` = 0.
- **Fault injection.** `q_fb` forced to 0 instead of the flip-flop, `pattern` = 8'hFF, `length` = 8 → `err_count` = 8, `err_flag` = 1.
- **Saturation.** Inverted feedback with `CNT_W` = 2 and `length` = 8 → `err_count` saturates at 3.
- **Boundaries.**
  - `length` = 0 → single-cycle `done`, `err_count` = 0.
  - `length` = 20 with `WIDTH` = 16 → 16 bits applied.
  - `start` pulsed mid-RUN → ignored.
- **Reset mid-sequence.** `reset` asserted at bit 5 of 16 → next edge `busy` = 0, j = k = 0, `err_count` = 0, no `done` pulse; a following `start` runs a clean sequence.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and the JK excitation-table lookup for the JK excitation sequencer.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  localparam int DC_HOLD   = 0;
  localparam int DC_TOGGLE = 1;

  // Returns {j, k} that moves a JK flip-flop from q to t; dc fills the don't-care input.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
    logic [1:0] jk;
    case ({q, t})
      2'b00:   jk = {1'b0, dc};
      2'b01:   jk = {1'b1, dc};
      2'b10:   jk = {dc, 1'b1};
      default: jk = {dc, 1'b0};
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_excitation_sequencer_cell.sv
// Combinational excitation-table cell; forces hold (j = k = 0) when not enabled.
module jk_excite_cell
  import jk_seq_pkg::*;
(
  input  logic i_enable,
  input  logic i_q,
  input  logic i_target,
  input  logic i_dc,
  output logic o_j,
  output logic o_k
);

  logic [1:0] w_jk;

  assign w_jk = i_enable ? jk_excite(i_q, i_target, i_dc) : 2'b00;
  assign o_j  = w_jk[1];
  assign o_k  = w_jk[0];

endmodule

// File: rtl/jk_excitation_sequencer.sv
// Drives a JK flip-flop so its Q follows a loaded bit pattern and counts cycles where Q missed.
module jk_excitation_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DC_POLICY = DC_HOLD,
  parameter int LEN_W     = $clog2(WIDTH + 1),
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_length,
  input  logic             i_q_fb,
  output logic             o_j,
  output logic             o_k,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_err_flag
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
  localparam logic             DC_BIT  = (DC_POLICY != DC_HOLD);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic             r_exp;
  logic             r_chk_vld;
  logic [CNT_W-1:0] r_err_count;

  logic [LEN_W-1:0] w_len_clamped;
  logic             w_run;
  logic             w_last;
  logic             w_mismatch;

  assign w_len_clamped = (i_length > MAX_LEN) ? MAX_LEN : i_length;
  assign w_run         = (r_state == ST_RUN);
  assign w_last        = (r_idx == (r_len - LEN_W'(1)));
  // Case inequality so an X/Z feedback in simulation also counts as a miss.
  assign w_mismatch    = (i_q_fb !== r_exp);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = (w_len_clamped == '0) ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (w_last) w_next_state = ST_FLUSH;
      ST_FLUSH: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // The pattern register shifts right so the current target is always bit 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_pattern   <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_exp       <= 1'b0;
      r_chk_vld   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_chk_vld && w_mismatch && (r_err_count != '1))
        r_err_count <= r_err_count + CNT_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_pattern   <= i_pattern;
            r_len       <= w_len_clamped;
            r_idx       <= '0;
            r_chk_vld   <= 1'b0;
            r_err_count <= '0;
          end
        end
        ST_RUN: begin
          r_exp     <= r_pattern[0];
          r_pattern <= r_pattern >> 1;
          r_chk_vld <= 1'b1;
          r_idx     <= r_idx + LEN_W'(1);
        end
        ST_FLUSH: r_chk_vld <= 1'b0;
        default:  r_chk_vld <= 1'b0;
      endcase
    end
  end

  jk_excite_cell u_cell (
    .i_enable (w_run),
    .i_q      (i_q_fb),
    .i_target (r_pattern[0]),
    .i_dc     (DC_BIT),
    .o_j      (o_j),
    .o_k      (o_k)
  );

  assign o_busy      = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign o_done      = (r_state == ST_FLUSH);
  assign o_err_count = r_err_count;
  assign o_err_flag  = |r_err_count;

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Directed bench: three sequencers (hold policy, toggle policy, 2-bit counter) each driving a JK flip-flop model.
module tb_jk_excitation_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  length;
  int          fbMode;

  logic       j1, k1, busy1, done1, flag1;
  logic [4:0] err1;
  logic       j2, k2, busy2, done2, flag2;
  logic [4:0] err2;
  logic       j3, k3, busy3, done3, flag3;
  logic [1:0] err3;

  logic ff1Q = 1'b0;
  logic ff2Q = 1'b0;
  logic ff3Q = 1'b0;
  logic qFb1, qFb3;

  int checks = 0;
  int errors = 0;
  int kViol = 0;
  int toggleViol = 0;
  int doneCount = 0;
  int cycles, gaps, doneBefore;

  // fbMode: 0 = real flip-flop Q, 1 = stuck at 0, 2 = inverted Q
  assign qFb1 = (fbMode == 0) ? ff1Q : (fbMode == 1) ? 1'b0 : ~ff1Q;
  assign qFb3 = (fbMode == 0) ? ff3Q : (fbMode == 1) ? 1'b0 : ~ff3Q;

  jk_excitation_sequencer #(.WIDTH(16), .DC_POLICY(0)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_pattern(pattern), .i_length(length),
    .i_q_fb(qFb1), .o_j(j1), .o_k(k1), .o_busy(busy1), .o_done(done1),
    .o_err_count(err1), .o_err_flag(flag1));

  jk_excitation_sequencer #(.WIDTH(16), .DC_POLICY(1)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_pattern(pattern), .i_length(length),
    .i_q_fb(ff2Q), .o_j(j2), .o_k(k2), .o_busy(busy2), .o_done(done2),
    .o_err_count(err2), .o_err_flag(flag2));

  jk_excitation_sequencer #(.WIDTH(16), .DC_POLICY(0), .CNT_W(2)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_pattern(pattern), .i_length(length),
    .i_q_fb(qFb3), .o_j(j3), .o_k(k3), .o_busy(busy3), .o_done(done3),
    .o_err_count(err3), .o_err_flag(flag3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic jkNext(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // Positive-edge JK flip-flops with their asynchronous reset held inactive.
  always @(posedge clk) begin
    ff1Q <= jkNext(ff1Q, j1, k1);
    ff2Q <= jkNext(ff2Q, j2, k2);
    ff3Q <= jkNext(ff3Q, j3, k3);
    if (busy2 && (jkNext(ff2Q, j2, k2) != ff2Q) && !(j2 && k2))
      toggleViol <= toggleViol + 1;
  end

  always @(negedge clk) begin
    if ((fbMode == 0) && busy1 && k1 && !ff1Q)
      kViol <= kViol + 1;
    if (done1)
      doneCount <= doneCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called on a negedge; returns on the negedge of the first cycle after the accepting edge.
  task automatic applyStimulus(input logic [15:0] pat, input logic [4:0] len);
    start   = 1'b1;
    pattern = pat;
    length  = len;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic waitDone(input int first, output int n, output int g);
    n = first;
    g = 0;
    while (!done1 && (n < 60)) begin
      if (!busy1) g++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    length  = '0;
    fbMode  = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_done", done1, 0);
    checkOutput("rst_err", err1, 0);
    checkOutput("rst_jk", {j1, k1}, 2'b00);

    // Alternating pattern, both policies
    applyStimulus(16'hA5A5, 5'd16);
    checkOutput("first_jk_hold", {j1, k1}, 2'b10);
    checkOutput("first_jk_toggle", {j2, k2}, 2'b11);
    waitDone(1, cycles, gaps);
    checkOutput("a5_done_cycle", cycles, 17);
    checkOutput("a5_busy_gaps", gaps, 0);
    checkOutput("a5_done2_align", done2, 1);
    checkOutput("flush_jk", {j1, k1}, 2'b00);
    @(negedge clk);
    checkOutput("a5_busy_after", busy1, 0);
    checkOutput("a5_err1", err1, 0);
    checkOutput("a5_err2", err2, 0);
    checkOutput("a5_flag2", flag2, 0);
    checkOutput("a5_k_while_q0", kViol, 0);
    checkOutput("a5_toggle_only", toggleViol, 0);
    checkOutput("a5_final_q", ff1Q, 1);

    // Zero length
    applyStimulus(16'hFFFF, 5'd0);
    waitDone(1, cycles, gaps);
    checkOutput("len0_done_cycle", cycles, 1);
    @(negedge clk);
    checkOutput("len0_busy", busy1, 0);
    checkOutput("len0_err", err1, 0);

    // Feedback stuck at 0
    fbMode = 1;
    applyStimulus(16'h00FF, 5'd8);
    waitDone(1, cycles, gaps);
    checkOutput("stuck_done_cycle", cycles, 9);
    @(negedge clk);
    checkOutput("stuck_err1", err1, 8);
    checkOutput("stuck_flag1", flag1, 1);
    checkOutput("stuck_err3_sat", err3, 3);
    checkOutput("stuck_flag3", flag3, 1);
    repeat (3) @(negedge clk);
    checkOutput("stuck_err_hold", err1, 8);

    // Inverted feedback: four mismatches, saturating the 2-bit counter
    fbMode = 2;
    applyStimulus(16'h00A5, 5'd8);
    waitDone(1, cycles, gaps);
    @(negedge clk);
    checkOutput("inv_err1", err1, 4);
    checkOutput("inv_err3_sat", err3, 3);
    fbMode = 0;

    // Over-long length clamps to 16 bits
    applyStimulus(16'h00FF, 5'd20);
    waitDone(1, cycles, gaps);
    checkOutput("clamp_done_cycle", cycles, 17);
    checkOutput("clamp_done3_align", done3, 1);
    @(negedge clk);
    checkOutput("clamp_err", err1, 0);
    checkOutput("clamp_final_q", ff1Q, 0);

    // Start mid-run is ignored
    applyStimulus(16'h5A5A, 5'd16);
    repeat (4) @(negedge clk);
    applyStimulus(16'h0000, 5'd0);
    waitDone(6, cycles, gaps);
    checkOutput("midstart_done_cycle", cycles, 17);
    repeat (4) @(negedge clk);
    checkOutput("midstart_not_queued", busy1, 0);
    checkOutput("midstart_err", err1, 0);

    // Reset at bit 5
    fbMode = 1;
    applyStimulus(16'hFFFF, 5'd16);
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_err", err1, 4);
    doneBefore = doneCount;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy", busy1, 0);
    checkOutput("mid_rst_busy3", busy3, 0);
    checkOutput("mid_rst_jk", {j1, k1}, 2'b00);
    checkOutput("mid_rst_err", err1, 0);
    checkOutput("mid_rst_flag", flag1, 0);
    checkOutput("mid_rst_done", done1, 0);
    reset  = 1'b0;
    fbMode = 0;
    repeat (20) @(negedge clk);
    checkOutput("mid_rst_no_done", doneCount, doneBefore);

    // Clean sequence after reset
    applyStimulus(16'h1234, 5'd16);
    waitDone(1, cycles, gaps);
    checkOutput("post_rst_done_cycle", cycles, 17);
    @(negedge clk);
    checkOutput("post_rst_err", err1, 0);
    checkOutput("post_rst_flag", flag1, 0);
    checkOutput("post_rst_err2", err2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
